pe_stream_arbiter: RTL and testbench
====================================

# pe_stream_arbiter

Shares the single DRAM streaming port (the MEM model that feeds IARAM and weight buffers) among `NUM_PE` processing elements. Each PE controller raises level requests for a filter stream or an input-activation stream. The arbiter picks one PE/type pair by round-robin, issues a valid/ready request to MEM, holds the grant until the matching stream-finish pulse, then routes that pulse back to the owning PE. It sits between the PE controllers and MEM in the multi-PE top level.

## Interface
Parameters:
- `NUM_PE`, default 4: number of requesting PEs; must be ≥ 2.
- `WDOG_CYCLES`, default 4096: stream watchdog limit. Used only when `STREAM_WATCHDOG_EN` is defined.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `pe_req_filter`  in  NUM_PE  per-PE filter-stream request, level.
- `pe_req_input`  in  NUM_PE  per-PE input-stream request, level.
- `pe_grant`  out  NUM_PE  one-hot owner of the DRAM port; all zero when no PE owns it.
- `pe_filter_finish`  out  NUM_PE  one-cycle filter-complete pulse to the owner.
- `pe_input_finish`  out  NUM_PE  one-cycle input-complete pulse to the owner.
- `mem_req_valid`  out  1  stream request valid to MEM.
- `mem_req_ready`  in  1  MEM accepts the request.
- `mem_req_type`  out  1  1 = filter stream, 0 = input stream.
- `mem_req_pe`  out  $clog2(NUM_PE)  index of the requesting PE.
- `mem_filter_finish`  in  1  MEM filter-stream-complete pulse.
- `mem_input_finish`  in  1  MEM input-stream-complete pulse.
- `arb_state`  out  2  current FSM state, for debug and testbench.
- `stream_timeout`  out  1  watchdog abort pulse. Present only with `STREAM_WATCHDOG_EN`.

## Operation
- FSM states: `ARB_IDLE`=0, `ARB_ISSUE`=1, `ARB_STREAM`=2, `ARB_RELEASE`=3.
- **ARB_IDLE**
  - A PE is eligible when `pe_req_filter|pe_req_input` is set for it.
  - The winner is the first eligible PE starting from `rr_ptr` and moving upward with wrap-around.
  - Within the winning PE, filter beats input, because weights must be resident before activations.
  - Winner index and type are registered; the FSM moves to ARB_ISSUE.
  - With no request, the FSM stays in ARB_IDLE.
- **ARB_ISSUE**
  - `mem_req_valid`=1.
  - `mem_req_type` and `mem_req_pe` are held stable until `mem_req_ready`.
  - On valid&ready the FSM moves to ARB_STREAM.
- **ARB_STREAM**
  - The FSM waits for the finish pulse matching the latched type.
  - A pulse of the other type is ignored.
  - If both pulses arrive in the same cycle, only the matching one counts.
- **ARB_RELEASE**
  - The finish pulse for the latched type is asserted on the owner bit for exactly this cycle.
  - `pe_grant` drops to 0.
  - `rr_ptr` ← (winner+1) mod NUM_PE.
  - The FSM returns to ARB_IDLE.
- `pe_grant` is asserted on the winner bit in ARB_ISSUE and ARB_STREAM.
- Finish pulses arriving outside ARB_STREAM are dropped.
- Request changes after winner selection do not affect the latched winner or type.
- A PE must deassert the satisfied request on the clock edge after its finish pulse. The next ARB_IDLE cycle then samples the updated request.

## Timing
- Reset values: all outputs 0, state ARB_IDLE, `rr_ptr`=0, watchdog counter 0.
- A reset mid-stream aborts without any finish pulse.
- Request seen in ARB_IDLE at cycle t:
  - `mem_req_valid` and `pe_grant` rise at t+1.
  - If `mem_req_ready` is already high at t+1, the FSM is in ARB_STREAM at t+2.
- MEM finish pulse at cycle s in ARB_STREAM: the PE finish pulse appears at s+1, and the FSM is in ARB_IDLE at s+2.
- Minimum arbitration overhead per stream: 3 cycles (IDLE, ISSUE, RELEASE).
- Back-to-back requests from the same PE: filter then input of one PE take two full arbitration rounds. Other waiting PEs are served in between because of round-robin.

## Configuration
- Macro: `STREAM_WATCHDOG_EN`.
- **Defined**
  - A counter of width `$clog2(WDOG_CYCLES+1)` clears on entry to ARB_STREAM and increments every ARB_STREAM cycle.
  - When it reaches WDOG_CYCLES with no matching finish, the FSM moves to ARB_RELEASE.
  - In that RELEASE cycle `stream_timeout` pulses for one cycle, no PE finish pulse is asserted, the grant drops and `rr_ptr` advances.
  - A matching finish in the same cycle as the limit wins: normal release, no timeout.
- **Not defined**
  - ARB_STREAM waits indefinitely.
  - No counter is built and the `stream_timeout` port is absent.

## Structure
- Shared package `pe_arb_pkg`:
  - the `arb_state_t` enum (2 bits);
  - `STREAM_FILTER`=1 and `STREAM_INPUT`=0 constants;
  - the latched grant struct (pe index, type).
- Sub-module `pe_rr_pick`: combinational round-robin picker. Inputs are the eligible vector and `rr_ptr`; outputs are a found flag and the winner index. It is reusable by other shared-resource arbiters.

## Test plan
- **Single PE:** PE2 raises filter at t; `mem_req_ready`=1 → `mem_req_pe`=2, type=1 at t+1; `mem_filter_finish` at t+5 → `pe_filter_finish`=4'b0100 at t+6.
- **Both types pending:** PE0 holds filter and input together → filter is served first; input is served in the next round after PE0 drops `pe_req_filter`.
- **Fairness:** all 4 PEs request input continuously → grant order 0,1,2,3,0; no PE is served twice before the others.
- **Backpressure and wrong type:**
  - `mem_req_ready` held low for 10 cycles → valid, type and pe stay stable and the FSM stays in ARB_ISSUE.
  - A `mem_input_finish` during a filter stream is ignored.
- **Reset mid-stream:** `rst` at cycle 3 of ARB_STREAM → next cycle all outputs 0, ARB_IDLE, `rr_ptr`=0, no finish pulse.
- **Watchdog** (`STREAM_WATCHDOG_EN`, WDOG_CYCLES=16): no finish for 16 cycles → `stream_timeout` pulses once, grant clears, no `pe_*_finish` pulse.

Source files
------------

// File: rtl/pe_arb_pkg.sv
// pe_arb_pkg: shared FSM states, stream-type codes and latched grant record for the PE stream arbiter
package pe_arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_STREAM  = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;
  localparam logic STREAM_FILTER = 1'b1;
  localparam logic STREAM_INPUT  = 1'b0;
  localparam int PE_IDX_W = 8;
  typedef struct packed {
    logic [PE_IDX_W-1:0] pe;
    logic                typ;
  } grant_t;
endpackage

// File: rtl/pe_stream_arbiter_if.sv
// pe_stream_arbiter_if: PE request/finish bundle plus MEM stream handshake for the shared DRAM port
//   master: arbiter side (drives grant, finishes, mem_req_*, arb_state[, stream_timeout])
//   slave : PE controllers + MEM side
//   stream_timeout exists only when STREAM_WATCHDOG_EN is defined
interface pe_stream_arbiter_if
  import pe_arb_pkg::*;
#(parameter int NUM_PE = 4);
  localparam int W = $clog2(NUM_PE);
  logic [NUM_PE-1:0] pe_req_filter;
  logic [NUM_PE-1:0] pe_req_input;
  logic [NUM_PE-1:0] pe_grant;
  logic [NUM_PE-1:0] pe_filter_finish;
  logic [NUM_PE-1:0] pe_input_finish;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_type;
  logic [W-1:0]      mem_req_pe;
  logic              mem_filter_finish;
  logic              mem_input_finish;
  arb_state_t        arb_state;
`ifdef STREAM_WATCHDOG_EN
  logic              stream_timeout;
`endif
  modport master (
    input  pe_req_filter, pe_req_input, mem_req_ready, mem_filter_finish, mem_input_finish,
`ifdef STREAM_WATCHDOG_EN
    output stream_timeout,
`endif
    output pe_grant, pe_filter_finish, pe_input_finish, mem_req_valid, mem_req_type, mem_req_pe, arb_state
  );
  modport slave (
    output pe_req_filter, pe_req_input, mem_req_ready, mem_filter_finish, mem_input_finish,
`ifdef STREAM_WATCHDOG_EN
    input  stream_timeout,
`endif
    input  pe_grant, pe_filter_finish, pe_input_finish, mem_req_valid, mem_req_type, mem_req_pe, arb_state
  );
endinterface

// File: rtl/pe_rr_pick.sv
// pe_rr_pick: combinational round-robin picker; first set bit of elig at or above ptr, wrapping
//   elig : eligible requesters     ptr : highest-priority index
//   found: any eligible            idx : winning index
module pe_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  int j;
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = 0;
    // Walk offsets from farthest to nearest so the nearest eligible one is written last.
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (elig[j]) begin
        found = 1'b1;
        idx = W'(j);
      end
    end
  end
endmodule

// File: rtl/pe_stream_arbiter.sv
// pe_stream_arbiter: round-robin owner of the shared DRAM streaming port among NUM_PE PEs
//   clk, rst (sync, active-high); bus (pe_stream_arbiter_if.master): PE level requests in,
//   one-hot grant and routed finish pulses out, valid/ready stream request to MEM.
//   Optional macro STREAM_WATCHDOG_EN adds a WDOG_CYCLES stream limit and stream_timeout.
module pe_stream_arbiter
  import pe_arb_pkg::*;
#(
  parameter int NUM_PE      = 4,
  parameter int WDOG_CYCLES = 4096
) (
  input logic               clk,
  input logic               rst,
  pe_stream_arbiter_if.master bus
);
  localparam int W = $clog2(NUM_PE);
  if (NUM_PE < 2 || WDOG_CYCLES < 1) begin : g_bad_cfg
    $error("pe_stream_arbiter: NUM_PE must be >= 2 and WDOG_CYCLES >= 1");
  end
  arb_state_t        state_q, state_d;
  grant_t            grant_q, grant_d;
  logic [W-1:0]      rr_q, rr_d;
  logic              tmo_q, tmo_d;
  logic              found;
  logic [W-1:0]      pick;
  logic              match;
  logic              wdog_hit;
  logic [NUM_PE-1:0] owner;
  logic [W-1:0]      rr_next;
  pe_rr_pick #(.N(NUM_PE), .W(W)) u_pick (
    .elig  (bus.pe_req_filter | bus.pe_req_input),
    .ptr   (rr_q),
    .found (found),
    .idx   (pick)
  );
  assign match   = grant_q.typ == STREAM_FILTER ? bus.mem_filter_finish : bus.mem_input_finish;
  assign owner   = NUM_PE'(1) << grant_q.pe;
  assign rr_next = int'(grant_q.pe) == NUM_PE - 1 ? '0 : W'(grant_q.pe + PE_IDX_W'(1));
`ifdef STREAM_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d    = state_q == ARB_STREAM ? cnt_q + CW'(1) : '0;
  assign wdog_hit = state_q == ARB_STREAM && cnt_d == CW'(WDOG_CYCLES);
  assign bus.stream_timeout = state_q == ARB_RELEASE && tmo_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`else
  assign wdog_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ARB_IDLE: if (found) begin
        grant_d.pe  = PE_IDX_W'(pick);
        grant_d.typ = bus.pe_req_filter[pick] ? STREAM_FILTER : STREAM_INPUT;
        state_d     = ARB_ISSUE;
      end
      ARB_ISSUE: state_d = bus.mem_req_ready ? ARB_STREAM : ARB_ISSUE;
      ARB_STREAM: begin
        state_d = match || wdog_hit ? ARB_RELEASE : ARB_STREAM;
        tmo_d   = !match && wdog_hit;
      end
      ARB_RELEASE: begin
        rr_d    = rr_next;
        tmo_d   = 1'b0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? ARB_IDLE : state_d;
    grant_q <= rst ? '0 : grant_d;
    rr_q    <= rst ? '0 : rr_d;
    tmo_q   <= rst ? 1'b0 : tmo_d;
  end
  assign bus.pe_grant         = state_q == ARB_ISSUE || state_q == ARB_STREAM ? owner : '0;
  assign bus.pe_filter_finish = state_q == ARB_RELEASE && !tmo_q && grant_q.typ == STREAM_FILTER ? owner : '0;
  assign bus.pe_input_finish  = state_q == ARB_RELEASE && !tmo_q && grant_q.typ == STREAM_INPUT ? owner : '0;
  assign bus.mem_req_valid    = state_q == ARB_ISSUE;
  assign bus.mem_req_type     = grant_q.typ;
  assign bus.mem_req_pe       = W'(grant_q.pe);
  assign bus.arb_state        = state_q;
endmodule

// File: tb/tb_pe_stream_arbiter.sv
// tb_pe_stream_arbiter: directed stimulus with a transaction-level model checked every cycle
module tb_pe_stream_arbiter;
  import pe_arb_pkg::*;
  localparam int NUM_PE = 4;
  localparam int WDOG = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  pe_stream_arbiter_if #(.NUM_PE(NUM_PE)) bus ();
  pe_stream_arbiter #(.NUM_PE(NUM_PE), .WDOG_CYCLES(WDOG)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Model: phase 0 waiting, 1 requesting MEM, 2 streaming, 3 handing the finish back.
  int m_ph, m_own, m_rr, m_cnt, m_best;
  bit m_typ, m_tmo;
  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_own = 0; m_rr = 0; m_cnt = 0; m_typ = 0; m_tmo = 0;
    end else if (m_ph == 0) begin
      m_best = -1;
      for (int p = 0; p < NUM_PE; p++)
        if ((bus.pe_req_filter[p] | bus.pe_req_input[p]) &&
            (m_best < 0 || (p - m_rr + NUM_PE) % NUM_PE < (m_best - m_rr + NUM_PE) % NUM_PE))
          m_best = p;
      if (m_best >= 0) begin
        m_own = m_best; m_typ = bus.pe_req_filter[m_best]; m_ph = 1;
      end
    end else if (m_ph == 1) begin
      if (bus.mem_req_ready) begin m_ph = 2; m_cnt = 0; end
    end else if (m_ph == 2) begin
      m_cnt++;
      if (m_typ ? bus.mem_filter_finish : bus.mem_input_finish) begin m_ph = 3; m_tmo = 0; end
`ifdef STREAM_WATCHDOG_EN
      else if (m_cnt == WDOG) begin m_ph = 3; m_tmo = 1; end
`endif
    end else begin
      m_ph = 0; m_rr = (m_own + 1) % NUM_PE;
    end
  end
  always @(posedge clk) begin
    #2;
    chk("m_state", bus.arb_state, m_ph);
    chk("m_grant", bus.pe_grant, (m_ph == 1 || m_ph == 2) ? (1 << m_own) : 0);
    chk("m_valid", bus.mem_req_valid, m_ph == 1);
    chk("m_ffin", bus.pe_filter_finish, (m_ph == 3 && !m_tmo && m_typ) ? (1 << m_own) : 0);
    chk("m_ifin", bus.pe_input_finish, (m_ph == 3 && !m_tmo && !m_typ) ? (1 << m_own) : 0);
`ifdef STREAM_WATCHDOG_EN
    chk("m_tmo", bus.stream_timeout, m_ph == 3 && m_tmo);
`endif
    if (m_ph == 1) begin
      chk("m_pe", bus.mem_req_pe, m_own);
      chk("m_type", bus.mem_req_type, m_typ);
    end
  end
  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (bus.arb_state !== s && n < budget) begin @(negedge clk); n++; end
    chk("wait_state", bus.arb_state, s);
  endtask
  task automatic serve(input int pe, input bit typ, input int bp, input bit wrong, input bit drop);
    wait_state(1, 20);
    chk("issue_pe", bus.mem_req_pe, pe);
    chk("issue_type", bus.mem_req_type, typ);
    chk("issue_grant", bus.pe_grant, 1 << pe);
    chk("model_pe", m_own, pe);
    repeat (bp) @(negedge clk);
    if (bp > 0) begin
      chk("bp_state", bus.arb_state, 1);
      chk("bp_pe", bus.mem_req_pe, pe);
      chk("bp_type", bus.mem_req_type, typ);
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("stream_state", bus.arb_state, 2);
    if (wrong) begin
      if (typ) bus.mem_input_finish = 1'b1; else bus.mem_filter_finish = 1'b1;
      @(negedge clk);
      bus.mem_input_finish = 1'b0; bus.mem_filter_finish = 1'b0;
      chk("wrong_ignored", bus.arb_state, 2);
    end
    @(negedge clk);
    if (typ) bus.mem_filter_finish = 1'b1; else bus.mem_input_finish = 1'b1;
    @(negedge clk);
    bus.mem_input_finish = 1'b0; bus.mem_filter_finish = 1'b0;
    chk("finish_own", typ ? bus.pe_filter_finish : bus.pe_input_finish, 1 << pe);
    chk("finish_other", typ ? bus.pe_input_finish : bus.pe_filter_finish, 0);
    chk("release_grant", bus.pe_grant, 0);
    if (drop) begin
      if (typ) bus.pe_req_filter[pe] = 1'b0; else bus.pe_req_input[pe] = 1'b0;
    end
    @(negedge clk);
    chk("back_idle", bus.arb_state, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not end, expected end before %0t", $time);
    $fatal(1);
  end
  initial begin
    bus.pe_req_filter = '0; bus.pe_req_input = '0; bus.mem_req_ready = 1'b0;
    bus.mem_filter_finish = 1'b0; bus.mem_input_finish = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_state", bus.arb_state, 0);
    chk("rst_grant", bus.pe_grant, 0);
    chk("rst_valid", bus.mem_req_valid, 0);
    chk("rst_pe", bus.mem_req_pe, 0);
    chk("rst_type", bus.mem_req_type, 0);
    bus.mem_filter_finish = 1'b1; bus.mem_input_finish = 1'b1;
    @(negedge clk);
    bus.mem_filter_finish = 1'b0; bus.mem_input_finish = 1'b0;
    chk("idle_drop_ff", bus.pe_filter_finish, 0);
    chk("idle_drop_if", bus.pe_input_finish, 0);
    chk("idle_stay", bus.arb_state, 0);
    bus.pe_req_filter[2] = 1'b1;
    serve(2, 1'b1, 0, 1'b0, 1'b1);
    bus.pe_req_filter[0] = 1'b1; bus.pe_req_input[0] = 1'b1;
    serve(0, 1'b1, 0, 1'b1, 1'b1);
    serve(0, 1'b0, 10, 1'b0, 1'b1);
    bus.pe_req_filter[3] = 1'b1;
    wait_state(1, 20);
    chk("rst_mid_pe", bus.mem_req_pe, 3);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_streaming", bus.arb_state, 2);
    rst = 1'b1; bus.pe_req_filter[3] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_state", bus.arb_state, 0);
    chk("rst_mid_grant", bus.pe_grant, 0);
    chk("rst_mid_valid", bus.mem_req_valid, 0);
    chk("rst_mid_ff", bus.pe_filter_finish, 0);
    chk("rst_mid_if", bus.pe_input_finish, 0);
    chk("rst_mid_pe0", bus.mem_req_pe, 0);
    repeat (2) @(negedge clk);
    bus.pe_req_input = '1;
    serve(0, 1'b0, 0, 1'b0, 1'b0);
    serve(1, 1'b0, 0, 1'b0, 1'b0);
    serve(2, 1'b0, 2, 1'b0, 1'b0);
    serve(3, 1'b0, 0, 1'b0, 1'b0);
    serve(0, 1'b0, 0, 1'b0, 1'b0);
    bus.pe_req_input = '0;
    @(negedge clk);
`ifdef STREAM_WATCHDOG_EN
    bus.pe_req_filter[1] = 1'b1;
    wait_state(1, 20);
    chk("wd_pe", bus.mem_req_pe, 1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0; bus.pe_req_filter[1] = 1'b0;
    wait_state(3, 40);
    chk("wd_timeout", bus.stream_timeout, 1);
    chk("wd_ff", bus.pe_filter_finish, 0);
    chk("wd_if", bus.pe_input_finish, 0);
    chk("wd_grant", bus.pe_grant, 0);
    @(negedge clk);
    chk("wd_idle", bus.arb_state, 0);
    chk("wd_once", bus.stream_timeout, 0);
`endif
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
